// File: rtl/vscale_iter_mul_div_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation (funct3) encodings, FSM states and small decode helpers.
package vscale_iter_mul_div_pkg;

    localparam int unsigned MD_OP_WIDTH = 3;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_OP_MUL    = 3'd0,
        MD_OP_MULH   = 3'd1,
        MD_OP_MULHSU = 3'd2,
        MD_OP_MULHU  = 3'd3,
        MD_OP_DIV    = 3'd4,
        MD_OP_DIVU   = 3'd5,
        MD_OP_REM    = 3'd6,
        MD_OP_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [2:0] {
        MD_STATE_IDLE,
        MD_STATE_SETUP,
        MD_STATE_COMPUTE,
        MD_STATE_FIXUP,
        MD_STATE_DONE
    } md_state_t;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic md_is_div(md_op_t op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV, REM.
    function automatic logic md_in_1_signed(md_op_t op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV, REM.
    function automatic logic md_in_2_signed(md_op_t op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/vscale_iter_mul_div_if.sv
// Request/response handshake bundle between the DX stage and the
// iterative multiply/divide unit. The pipeline side is the master.
interface vscale_iter_mul_div_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_in_1;
    logic [XLEN-1:0] req_in_2;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output req_valid, req_op, req_in_1, req_in_2, kill, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_in_1, req_in_2, kill, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/vscale_iter_mul_div.sv
// Iterative RV32M multiply/divide unit. One bit per cycle for XLEN cycles:
// shift-add multiply or restoring divide on sign-stripped magnitudes, with
// the sign applied once at the end. Single shared 33-bit adder/subtractor.
module vscale_iter_mul_div
    import vscale_iter_mul_div_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic                clk,
    input logic                reset_n,
    vscale_iter_mul_div_if.slave md
);

    md_state_t           state;
    md_state_t           state_next;
    md_op_t              op_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic                sign_1_q;
    logic                sign_2_q;
    logic                negate_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                last_iter;
    logic [XLEN:0]       alu_a;
    logic [XLEN:0]       alu_b;
    logic [XLEN:0]       alu_out;
    logic                q_bit;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   acc_neg;
    logic [XLEN-1:0]     lo_fix;
    logic [XLEN-1:0]     hi_fix_mul;
    logic [XLEN-1:0]     hi_fix_rem;
    logic [XLEN-1:0]     result_fix;

    assign accept          = (state == MD_STATE_IDLE) && md.req_valid && !md.kill;
    assign last_iter       = (cnt_q == CNT_W'(XLEN-1));
    assign md.req_ready    = (state == MD_STATE_IDLE);
    assign md.resp_valid   = (state == MD_STATE_DONE);
    assign md.resp_result  = result_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= MD_STATE_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; kill returns any busy state to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            MD_STATE_IDLE:    if (accept) state_next = MD_STATE_SETUP;
            MD_STATE_SETUP:   state_next = MD_STATE_COMPUTE;
            MD_STATE_COMPUTE: if (last_iter) state_next = MD_STATE_FIXUP;
            MD_STATE_FIXUP:   state_next = MD_STATE_DONE;
            MD_STATE_DONE:    if (md.resp_ready) state_next = MD_STATE_IDLE;
            default:          state_next = MD_STATE_IDLE;
        endcase
        if (md.kill && (state != MD_STATE_IDLE)) state_next = MD_STATE_IDLE;
    end

    // Shared adder/subtractor and the per-iteration accumulator update.
    // Divide: acc = {remainder, dividend-shifting-into-quotient}. The trial
    // subtract uses bits [2X-2:X-1]; a set acc[2X-1] means the shifted
    // remainder already exceeds any divisor, so the quotient bit is forced.
    always_comb begin
        alu_a = '0;
        alu_b = {1'b0, b_q};
        if (md_is_div(op_q)) begin
            alu_a   = {1'b0, acc_q[2*XLEN-2:XLEN-1]};
            alu_out = alu_a - alu_b;
            q_bit   = acc_q[2*XLEN-1] | !alu_out[XLEN];
            if (q_bit) acc_next = {alu_out[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else       acc_next = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            alu_a   = {1'b0, acc_q[2*XLEN-1:XLEN]};
            alu_out = alu_a + alu_b;
            q_bit   = 1'b0;
            if (acc_q[0]) acc_next = {alu_out, acc_q[XLEN-1:1]};
            else          acc_next = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Sign fixup and output half select.
    always_comb begin
        acc_neg    = -acc_q;
        lo_fix     = negate_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
        hi_fix_mul = negate_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        hi_fix_rem = negate_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: result_fix = hi_fix_mul;
            MD_OP_REM, MD_OP_REMU:                 result_fix = hi_fix_rem;
            default:                               result_fix = lo_fix;
        endcase
    end

    // Datapath registers: operand latch, magnitudes, iteration, result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= MD_OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            sign_1_q <= 1'b0;
            sign_2_q <= 1'b0;
            negate_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                MD_STATE_IDLE: begin
                    if (accept) begin
                        op_q     <= md_op_t'(md.req_op);
                        a_q      <= md.req_in_1;
                        b_q      <= md.req_in_2;
                        sign_1_q <= md.req_in_1[XLEN-1] && md_in_1_signed(md_op_t'(md.req_op));
                        sign_2_q <= md.req_in_2[XLEN-1] && md_in_2_signed(md_op_t'(md.req_op));
                    end
                end
                MD_STATE_SETUP: begin
                    acc_q <= {{XLEN{1'b0}}, (sign_1_q ? -a_q : a_q)};
                    b_q   <= sign_2_q ? -b_q : b_q;
                    cnt_q <= '0;
                    case (op_q)
                        MD_OP_DIV, MD_OP_DIVU: negate_q <= (sign_1_q ^ sign_2_q) && (b_q != '0);
                        MD_OP_REM, MD_OP_REMU: negate_q <= sign_1_q;
                        default:               negate_q <= sign_1_q ^ sign_2_q;
                    endcase
                end
                MD_STATE_COMPUTE: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                MD_STATE_FIXUP: begin
                    result_q <= result_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_iter_mul_div.sv
// Self-checking bench for the iterative multiply/divide unit. Expected
// results come from a behavioural RISC-V model and flow through a queue.
module tb_vscale_iter_mul_div;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] exp_q[$];

    vscale_iter_mul_div_if #(.XLEN(32)) md ();

    vscale_iter_mul_div #(.XLEN(32), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y, p;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a}; y = {32'b0, b}; p = x * y; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, optionally check latency and stall behaviour in DONE,
    // then compare the response against the queued expectation.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit chk_lat, input int hold);
        int lat;
        logic stable;
        logic [31:0] first;
        logic [31:0] exp;
        exp_q.push_back(model(op, a, b));
        md.req_op = op; md.req_in_1 = a; md.req_in_2 = b; md.req_valid = 1'b1;
        @(posedge clk); #1;
        md.req_valid = 1'b0;
        md.req_op = 3'($urandom); md.req_in_1 = $urandom; md.req_in_2 = $urandom;
        lat = 1;
        while (!md.resp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!md.resp_valid) begin
            check_eq("resp_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        if (chk_lat) check_eq("latency", lat, 35);
        if (hold > 0) begin
            stable = 1'b1;
            first = md.resp_result;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!md.resp_valid || md.req_ready || md.resp_result !== first) stable = 1'b0;
            end
            check_eq("done_hold_stable", stable, 1);
        end
        exp = exp_q.pop_front();
        check_eq($sformatf("result op%0d %h,%h", op, a, b), md.resp_result, exp);
        md.resp_ready = 1'b1;
        @(posedge clk); #1;
        md.resp_ready = 1'b0;
        check_eq("resp_valid_drop", md.resp_valid, 0);
    endtask

    initial begin
        int seen;
        md.req_valid = 0; md.req_op = 0; md.req_in_1 = 0; md.req_in_2 = 0;
        md.kill = 0; md.resp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", md.req_ready, 1);
        check_eq("rst_resp_valid", md.resp_valid, 0);
        check_eq("rst_resp_result", md.resp_result, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'd5, 32'd7, 32'd2, 0, 0);
        run_op(3'd7, 32'd7, 32'd2, 0, 0);
        run_op(3'd4, 32'd5, 32'd0, 0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0, 0);
        run_op(3'd5, 32'd5, 32'd0, 0, 0);
        run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

        // Kill with a request offered in IDLE: nothing is accepted.
        md.req_op = 3'd0; md.req_in_1 = 3; md.req_in_2 = 4;
        md.req_valid = 1'b1; md.kill = 1'b1;
        @(posedge clk); #1;
        md.req_valid = 1'b0; md.kill = 1'b0;
        check_eq("idle_kill_ready", md.req_ready, 1);

        // Kill ten cycles into COMPUTE.
        md.req_op = 3'd0; md.req_in_1 = 32'h1234; md.req_in_2 = 32'h5678; md.req_valid = 1'b1;
        @(posedge clk); #1;
        md.req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check_eq("busy_before_kill", md.req_ready, 0);
        md.kill = 1'b1;
        @(posedge clk); #1;
        md.kill = 1'b0;
        check_eq("kill_ready", md.req_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md.resp_valid) seen++;
        end
        check_eq("kill_no_resp", seen, 0);
        run_op(3'd0, 32'd3, 32'd4, 0, 0);

        // Consumer stalls five cycles in DONE.
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1, 5);

        // Random operations.
        for (int i = 0; i < 12; i++)
            run_op(3'($urandom_range(0, 7)), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom, 0, 0);

        // Reset pulse mid-COMPUTE.
        md.req_op = 3'd4; md.req_in_1 = 32'd1000; md.req_in_2 = 32'd7; md.req_valid = 1'b1;
        @(posedge clk); #1;
        md.req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check_eq("midrst_req_ready", md.req_ready, 1);
        check_eq("midrst_resp_valid", md.resp_valid, 0);
        check_eq("midrst_resp_result", md.resp_result, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_ready", md.req_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md.resp_valid) seen++;
        end
        check_eq("post_rst_no_resp", seen, 0);
        run_op(3'd7, 32'd1000, 32'd7, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
